hyperbus_cmd_addr_decoder: RTL and testbench

Device-side counterpart of the HyperBus command-address generator. It deserializes the 48-bit command-address (CA) word from the byte stream delivered by the DDR capture front end while chip select is active. It decodes the word into the read/write, address-space, burst-type and 32-bit address fields and presents them on a valid/ready handshake to the memory/register model. It sits between the PHY byte deserializer and the device transaction engine in the HyperBus responder/testbench path.

---
 rtl/hyperbus_cmd_addr_decoder.sv | 108 ++++++++++
 tb/tb_hyperbus_cmd_addr_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_cmd_addr_decoder.sv
// HyperBus command-address decoder (device side).
// Collects the six CA bytes that follow chip-select assertion, splits the
// 48-bit word into its fields and offers them on a valid/ready handshake.
// Once the consumer accepts the fields, the block marks the data phase
// until chip select is released.
module hyperbus_cmd_addr_decoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_ni,
  input  logic [7:0]  dq_i,
  input  logic        dq_valid_i,
  output logic        ca_valid_o,
  input  logic        ca_ready_i,
  output logic        rw_o,
  output logic        address_space_o,
  output logic        burst_type_o,
  output logic [31:0] address_o,
  output logic        reserved_err_o,
  output logic        data_phase_o,
  output logic        abort_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    VALID   = 2'd2,
    DATA    = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  count;
  logic [47:0] ca_shift;
  logic        abort_q;

  // Sequencer: captures CA bytes, holds them for the handshake, and handles
  // chip-select release (flagging an abort if the CA was never handed off).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= 3'd0;
      ca_shift <= 48'd0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_ni) begin
            count <= 3'd0;
          end else if (dq_valid_i) begin
            ca_shift <= {ca_shift[39:0], dq_i};
            count    <= 3'd1;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cs_ni) begin
            state   <= IDLE;
            count   <= 3'd0;
            abort_q <= 1'b1;
          end else if (dq_valid_i) begin
            ca_shift <= {ca_shift[39:0], dq_i};
            if (count == 3'd5) begin
              count <= 3'd0;
              state <= VALID;
            end else begin
              count <= count + 3'd1;
            end
          end
        end
        VALID: begin
          // A handshake in the same cycle as CS release still counts as
          // delivered, so it goes straight to IDLE without an abort.
          if (ca_ready_i) begin
            state <= cs_ni ? IDLE : DATA;
            count <= 3'd0;
          end else if (cs_ni) begin
            state   <= IDLE;
            count   <= 3'd0;
            abort_q <= 1'b1;
          end
        end
        DATA: begin
          if (cs_ni) begin
            state <= IDLE;
            count <= 3'd0;
          end
        end
        default: begin
          state <= IDLE;
          count <= 3'd0;
        end
      endcase
    end
  end

  // Field decode straight from the shift register, which is frozen in VALID.
  always_comb begin
    ca_valid_o      = (state == VALID);
    data_phase_o    = (state == DATA);
    abort_o         = abort_q;
    rw_o            = ca_shift[47];
    address_space_o = ca_shift[46];
    burst_type_o    = ca_shift[45];
    address_o       = {ca_shift[44:16], ca_shift[2:0]};
    reserved_err_o  = ca_valid_o && (ca_shift[15:3] != 13'd0);
  end

endmodule

// File: tb/tb_hyperbus_cmd_addr_decoder.sv
// Directed testbench for hyperbus_cmd_addr_decoder.
module tb_hyperbus_cmd_addr_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cs_ni = 1'b1;
  logic [7:0]  dq_i = 8'h00;
  logic        dq_valid_i = 1'b0;
  logic        ca_ready_i = 1'b0;
  logic        ca_valid_o;
  logic        rw_o;
  logic        address_space_o;
  logic        burst_type_o;
  logic [31:0] address_o;
  logic        reserved_err_o;
  logic        data_phase_o;
  logic        abort_o;

  int check_count = 0;
  int pass_count  = 0;

  hyperbus_cmd_addr_decoder dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cs_ni           (cs_ni),
    .dq_i            (dq_i),
    .dq_valid_i      (dq_valid_i),
    .ca_valid_o      (ca_valid_o),
    .ca_ready_i      (ca_ready_i),
    .rw_o            (rw_o),
    .address_space_o (address_space_o),
    .burst_type_o    (burst_type_o),
    .address_o       (address_o),
    .reserved_err_o  (reserved_err_o),
    .data_phase_o    (data_phase_o),
    .abort_o         (abort_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic cs, input logic dqv,
                               input logic [7:0] dq, input logic rdy);
    cs_ni      = cs;
    dq_valid_i = dqv;
    dq_i       = dq;
    ca_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic checkFields(input string tag, input logic rw, input logic asp,
                             input logic bt, input logic [31:0] addr,
                             input logic err);
    checkOutput({tag, ".valid"}, {31'd0, ca_valid_o}, 32'd1);
    checkOutput({tag, ".rw"}, {31'd0, rw_o}, {31'd0, rw});
    checkOutput({tag, ".aspace"}, {31'd0, address_space_o}, {31'd0, asp});
    checkOutput({tag, ".burst"}, {31'd0, burst_type_o}, {31'd0, bt});
    checkOutput({tag, ".addr"}, address_o, addr);
    checkOutput({tag, ".rsv"}, {31'd0, reserved_err_o}, {31'd0, err});
  endtask

  initial begin
    $display("[TB] start");
    // Reset
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("rst.valid", {31'd0, ca_valid_o}, 32'd0);
    checkOutput("rst.data", {31'd0, data_phase_o}, 32'd0);
    checkOutput("rst.abort", {31'd0, abort_o}, 32'd0);
    checkOutput("rst.addr", address_o, 32'd0);
    checkOutput("rst.rw", {31'd0, rw_o}, 32'd0);
    rst_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    // Linear memory read
    $display("[TB] linear memory read");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rd.idle_nocap", {31'd0, ca_valid_o}, 32'd0);
    sendByte(8'hA0); sendByte(8'h02); sendByte(8'h46);
    sendByte(8'h8A); sendByte(8'h00);
    checkOutput("rd.valid_early", {31'd0, ca_valid_o}, 32'd0);
    sendByte(8'h07);
    checkFields("rd", 1'b1, 1'b0, 1'b1, 32'h0012_3457, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("rd.data_phase", {31'd0, data_phase_o}, 32'd1);
    checkOutput("rd.valid_drop", {31'd0, ca_valid_o}, 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
    checkOutput("rd.data_hold", {31'd0, data_phase_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("rd.data_end", {31'd0, data_phase_o}, 32'd0);
    checkOutput("rd.no_abort", {31'd0, abort_o}, 32'd0);

    // Wrapped register write, back-to-back after a single CS-high cycle
    $display("[TB] wrapped register write");
    sendByte(8'h40); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    checkFields("wr", 1'b0, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("wr.data_phase", {31'd0, data_phase_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    // Reserved bits, then CS release together with the handshake
    $display("[TB] reserved bits and handshake on CS release");
    sendByte(8'hA0); sendByte(8'h02); sendByte(8'h46);
    sendByte(8'h8A); sendByte(8'h00); sendByte(8'h0F);
    checkFields("rsv", 1'b1, 1'b0, 1'b1, 32'h0012_3457, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("hscs.valid", {31'd0, ca_valid_o}, 32'd0);
    checkOutput("hscs.abort", {31'd0, abort_o}, 32'd0);
    checkOutput("hscs.data", {31'd0, data_phase_o}, 32'd0);
    checkOutput("hscs.rsv_gated", {31'd0, reserved_err_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("hscs.abort_late", {31'd0, abort_o}, 32'd0);

    // CS release while in VALID without ready
    $display("[TB] CS release in VALID");
    sendByte(8'h40); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    checkOutput("vrel.valid_pre", {31'd0, ca_valid_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("vrel.abort", {31'd0, abort_o}, 32'd1);
    checkOutput("vrel.valid", {31'd0, ca_valid_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("vrel.abort_end", {31'd0, abort_o}, 32'd0);

    // Abort mid-capture
    $display("[TB] abort during capture");
    sendByte(8'hA0); sendByte(8'h02); sendByte(8'h46);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("abt.pulse", {31'd0, abort_o}, 32'd1);
    checkOutput("abt.valid", {31'd0, ca_valid_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("abt.pulse_end", {31'd0, abort_o}, 32'd0);
    sendByte(8'hA0); sendByte(8'h02); sendByte(8'h46);
    sendByte(8'h8A); sendByte(8'h00); sendByte(8'h07);
    checkFields("abt.next", 1'b1, 1'b0, 1'b1, 32'h0012_3457, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    // Gaps between bytes, backpressure, stray bytes during VALID
    $display("[TB] backpressure with gaps");
    sendByte(8'h40);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b0);
    sendByte(8'h00);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b0);
    sendByte(8'h00); sendByte(8'h00);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b0);
    sendByte(8'h00);
    checkOutput("bp.valid_early", {31'd0, ca_valid_o}, 32'd0);
    sendByte(8'h01);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
      checkFields("bp.hold", 1'b0, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
    checkOutput("bp.data_phase", {31'd0, data_phase_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
    checkOutput("bp.single_hs", {31'd0, ca_valid_o}, 32'd0);
    checkOutput("bp.addr_kept", address_o, 32'h0000_0001);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset mid-capture
    $display("[TB] reset during capture");
    sendByte(8'hA0); sendByte(8'h02); sendByte(8'h46); sendByte(8'h8A);
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    rst_i = 1'b0;
    checkOutput("mrst.valid", {31'd0, ca_valid_o}, 32'd0);
    checkOutput("mrst.abort", {31'd0, abort_o}, 32'd0);
    checkOutput("mrst.addr", address_o, 32'd0);
    checkOutput("mrst.rw", {31'd0, rw_o}, 32'd0);
    checkOutput("mrst.burst", {31'd0, burst_type_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("mrst.abort_late", {31'd0, abort_o}, 32'd0);
    sendByte(8'h40); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    checkFields("mrst.next", 1'b0, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("mrst.data_phase", {31'd0, data_phase_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
